sw_sb_ctrl_p: RTL and testbench

SW_SB_CTRL_P -- requirements
Module: sw_sb_ctrl_p

---
 rtl/sw_sb_ctrl_p.sv | 164 ++++++++++++++++
 tb/tb_sw_sb_ctrl_p.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sw_sb_ctrl_p.sv
// rtl/sw_sb_ctrl_p.sv - debounced switch bank with edge status, mask and level interrupt
module sw_sb_ctrl_p #(
    parameter int               WIDTH   = 16,
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] DEB_RST = 16'd1000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      write_data_i,
    output logic [31:0]      read_data_o,
    output logic             interrupt_request_o,
    input  logic             interrupt_return_i,
    input  logic [WIDTH-1:0] sw_i
);

    localparam logic [31:0] IDLE_WORD  = 32'hfa11_1eaf;
    localparam logic [31:0] ERROR_WORD = 32'hdead_beef;

    localparam logic [2:0] IDX_DATA   = 3'd0;
    localparam logic [2:0] IDX_MASK   = 3'd1;
    localparam logic [2:0] IDX_STATUS = 3'd2;
    localparam logic [2:0] IDX_RISE   = 3'd3;
    localparam logic [2:0] IDX_FALL   = 3'd4;
    localparam logic [2:0] IDX_DEB    = 3'd5;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [CNT_W-1:0] deb_m1;
    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;
    logic [WIDTH-1:0] set_ev;
    logic [WIDTH-1:0] clr;
    logic             hit;
    logic             wr;
    logic [2:0]       idx;

    assign idx = addr_i[4:2];
    // Word-aligned addresses inside the six-register window are the only mapped ones.
    assign hit = (addr_i[1:0] == 2'b00) && (addr_i[31:5] == 27'd0) && (idx <= IDX_DEB);
    assign wr  = req_i && write_enable_i && hit;

    // Two-flop synchronizer in front of the debouncers.
    always_comb begin
        sync1_d = sw_i;
        sync2_d = sync1_q;
    end

    // Per-bit debouncer; a threshold of 0 is treated as 1, and >= lets a shrunken
    // threshold commit on the next differing cycle without the counter wrapping.
    always_comb begin
        deb_m1  = (deb_q == '0) ? '0 : deb_q - CNT_W'(1);
        stable_d = stable_q;
        rise_ev  = '0;
        fall_ev  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= deb_m1) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                rise_ev[i]  = sync2_q[i];
                fall_ev[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Register file updates; a fresh edge event beats any clear on the same cycle.
    always_comb begin
        set_ev = (rise_ev & rise_q) | (fall_ev & fall_q);
        clr    = '0;
        if (interrupt_return_i) begin
            clr = '1;
        end
        if (wr && idx == IDX_STATUS) begin
            clr = clr | write_data_i[WIDTH-1:0];
        end
        status_d = (status_q & ~clr) | set_ev;
        mask_d   = mask_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        deb_d    = deb_q;
        if (wr) begin
            case (idx)
                IDX_MASK: mask_d = write_data_i[WIDTH-1:0];
                IDX_RISE: rise_d = write_data_i[WIDTH-1:0];
                IDX_FALL: fall_d = write_data_i[WIDTH-1:0];
                IDX_DEB:  deb_d  = write_data_i[CNT_W-1:0];
                default:  ;
            endcase
        end
    end

    // Read mux producing next-cycle read data.
    always_comb begin
        rdata_d = IDLE_WORD;
        if (req_i && !write_enable_i) begin
            if (hit) begin
                rdata_d = '0;
                case (idx)
                    IDX_DATA:   rdata_d[WIDTH-1:0] = stable_q;
                    IDX_MASK:   rdata_d[WIDTH-1:0] = mask_q;
                    IDX_STATUS: rdata_d[WIDTH-1:0] = status_q;
                    IDX_RISE:   rdata_d[WIDTH-1:0] = rise_q;
                    IDX_FALL:   rdata_d[WIDTH-1:0] = fall_q;
                    IDX_DEB:    rdata_d[CNT_W-1:0] = deb_q;
                    default:    rdata_d = ERROR_WORD;
                endcase
            end else begin
                rdata_d = ERROR_WORD;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            status_q <= '0;
            mask_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            deb_q    <= DEB_RST;
            rdata_q  <= IDLE_WORD;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            status_q <= status_d;
            mask_q   <= mask_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            deb_q    <= deb_d;
            rdata_q  <= rdata_d;
        end
    end

    assign read_data_o         = rdata_q;
    assign interrupt_request_o = |(status_q & mask_q);

endmodule

// File: tb/tb_sw_sb_ctrl_p.sv
// tb/tb_sw_sb_ctrl_p.sv - directed self-checking bench for sw_sb_ctrl_p
module tb_sw_sb_ctrl_p;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        write_enable_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] write_data_i = '0;
    logic [31:0] read_data_o;
    logic        interrupt_request_o;
    logic        interrupt_return_i = 1'b0;
    logic [15:0] sw_i = '0;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;

    sw_sb_ctrl_p dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .req_i               (req_i),
        .write_enable_i      (write_enable_i),
        .addr_i              (addr_i),
        .write_data_i        (write_data_i),
        .read_data_o         (read_data_o),
        .interrupt_request_o (interrupt_request_o),
        .interrupt_return_i  (interrupt_return_i),
        .sw_i                (sw_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
        @(negedge clk_i);
        req_i = 1'b0; write_enable_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk_i);
        req_i = 1'b1; write_enable_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        d = read_data_o;
        req_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        // reset state
        #12;
        check("rst_rdata", read_data_o, 32'hfa11_1eaf);
        check("rst_irq", {31'd0, interrupt_request_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // bus reads
        bus_read(32'h14, rd); check("deb_rst", rd, 32'd1000);
        bus_read(32'h18, rd); check("unmapped", rd, 32'hdead_beef);
        bus_read(32'h02, rd); check("misaligned", rd, 32'hdead_beef);
        @(negedge clk_i);
        check("idle", read_data_o, 32'hfa11_1eaf);

        // rising edge on bit 0, DEB=4: interrupt exactly 6 cycles after the change
        bus_write(32'h14, 32'd4);
        bus_write(32'h0C, 32'h1);
        bus_write(32'h04, 32'h1);
        sw_i[0] = 1'b1;
        cycles(5);
        check("irq_c5", {31'd0, interrupt_request_o}, 32'd0);
        cycles(1);
        check("irq_c6", {31'd0, interrupt_request_o}, 32'd1);
        bus_read(32'h00, rd); check("data_b0", rd, 32'h1);
        bus_read(32'h08, rd); check("status_b0", rd, 32'h1);
        bus_write(32'h08, 32'h1);
        check("w1c_irq", {31'd0, interrupt_request_o}, 32'd0);

        // 3-cycle glitch on bit 3 is rejected
        sw_i[3] = 1'b1;
        cycles(3);
        sw_i[3] = 1'b0;
        cycles(10);
        bus_read(32'h00, rd); check("glitch_data", rd, 32'h1);
        bus_read(32'h08, rd); check("glitch_status", rd, 32'h0);
        check("glitch_irq", {31'd0, interrupt_request_o}, 32'd0);

        // falling edge on bit 5, masked then unmasked, then W1C
        bus_write(32'h10, 32'h20);
        sw_i[5] = 1'b1;
        cycles(10);
        sw_i[5] = 1'b0;
        cycles(10);
        bus_read(32'h08, rd); check("fall_status", rd, 32'h20);
        check("fall_irq_masked", {31'd0, interrupt_request_o}, 32'd0);
        bus_write(32'h04, 32'h21);
        check("fall_irq_unmasked", {31'd0, interrupt_request_o}, 32'd1);
        bus_write(32'h08, 32'h20);
        check("fall_irq_w1c", {31'd0, interrupt_request_o}, 32'd0);
        bus_read(32'h08, rd); check("fall_status_w1c", rd, 32'h0);

        // interrupt return coincides with a new edge on bit 2
        bus_write(32'h0C, 32'h85);
        bus_write(32'h04, 32'hA5);
        sw_i[5] = 1'b1;
        cycles(10);
        sw_i[5] = 1'b0;
        cycles(10);
        sw_i[2] = 1'b1;
        cycles(5);
        interrupt_return_i = 1'b1;
        cycles(1);
        interrupt_return_i = 1'b0;
        check("ret_irq", {31'd0, interrupt_request_o}, 32'd1);
        bus_read(32'h08, rd); check("ret_status", rd, 32'h4);

        // write to DATA is ignored
        bus_write(32'h00, 32'h0);
        bus_read(32'h00, rd); check("data_ro", rd, 32'h5);

        // DEB=0 behaves as DEB=1
        bus_write(32'h14, 32'd0);
        bus_read(32'h14, rd); check("deb_zero_rd", rd, 32'd0);
        interrupt_return_i = 1'b1;
        cycles(1);
        interrupt_return_i = 1'b0;
        check("ret_clear_irq", {31'd0, interrupt_request_o}, 32'd0);
        sw_i[7] = 1'b1;
        cycles(2);
        check("deb0_c2", {31'd0, interrupt_request_o}, 32'd0);
        cycles(1);
        check("deb0_c3", {31'd0, interrupt_request_o}, 32'd1);

        // STATUS=0xFF, then asynchronous reset mid-debounce
        bus_write(32'h14, 32'd1);
        bus_write(32'h0C, 32'hFF);
        bus_write(32'h10, 32'hFF);
        bus_write(32'h04, 32'hFF);
        sw_i = 16'h007A;
        cycles(5);
        bus_read(32'h08, rd); check("status_ff", rd, 32'hFF);
        bus_write(32'h14, 32'd4);
        sw_i = 16'h0085;
        cycles(2);
        @(negedge clk_i);
        req_i = 1'b1; write_enable_i = 1'b0; addr_i = 32'h08;
        @(posedge clk_i);
        #2;
        check("pre_rst_rdata", read_data_o, 32'hFF);
        check("pre_rst_irq", {31'd0, interrupt_request_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("async_rdata", read_data_o, 32'hfa11_1eaf);
        check("async_irq", {31'd0, interrupt_request_o}, 32'd0);
        req_i = 1'b0;
        sw_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycles(20);
        check("post_rst_irq", {31'd0, interrupt_request_o}, 32'd0);
        bus_read(32'h08, rd); check("post_rst_status", rd, 32'h0);
        bus_read(32'h14, rd); check("post_rst_deb", rd, 32'd1000);
        bus_read(32'h00, rd); check("post_rst_data", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
